aes_128_key_expand_4cyc: RTL and testbench
==========================================

Name: aes_128_key_expand_4cyc

Overview:
- Upstream round-key source for aes_128_core_full_4cyc.
- Takes a 128-bit cipher key and expands it into round keys 1..10. Uses one shared 8-bit S-box ROM, one SubWord byte per cycle, so each round takes 4 cycles.
- Stores the round keys in a 10x128 register file. Drives the core's key_round input in lock-step with the core's key_ready requests.
- Byte ordering matches the core: AES byte 0 is at bits [7:0].

Parameters:
- NR, 10, number of expanded round keys. Fixed for AES-128; the block is not required to support other values.
- CYC_PER_RND, 4, cycles per expansion round. Fixed.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- kill  in  1  synchronous, active-high reset.
- key_in  in  128  cipher key; byte 0 at [7:0].
- key_load  in  1  one-cycle pulse; samples key_in and starts expansion.
- key_valid  out  1  high when all 10 round keys are stored and serving is enabled.
- core_in_en  in  1  the core's in_en; marks the start of a new block.
- core_key_ready  in  1  the core's key_ready; a request for the next round key.
- core_out_en  in  1  the core's out_en; marks the end of a block.
- key_round  out  128  registered key to the core's key_round input.

Behaviour:
- Reset (kill high at an edge):
  - State goes to IDLE; key_valid = 0; key_round = 0; idx = 1.
  - Register-file contents are don't-care.
  - kill overrides every other input, including mid-expansion and mid-serve.
- FSM states are IDLE, EXPAND and READY.
- key_load (accepted in any state):
  - At the sampling edge: rk0 <= key_in; key_round <= key_in; key_valid <= 0; rnd <= 1; byte counter <= 0; state <= EXPAND.
  - A key_load during EXPAND restarts the expansion from the new key.
- EXPAND, per round r = 1..10:
  - Words w0..w3 are the previous round key, with w0 = [31:0].
  - temp = RotWord(w3) = {w3[7:0], w3[31:8]}.
  - Cycles 0..3: one S-box lookup per cycle on byte k of temp, stored into the sub register.
  - Cycle 3 edge: byte [7:0] of the sub result is XORed with Rcon[r].
    - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Cycle 3 edge: w0' = w0 ^ sub; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'. Result is written to rk[r].
  - The round counter rnd advances on the same edge.
  - After rk10 is written (40 edges after the key_load edge): state <= READY; key_valid <= 1.
- READY, serving:
  - core_in_en: idx <= 1; key_round <= rk0.
  - core_key_ready with idx <= 10: key_round <= rk[idx]; idx <= idx + 1. The new key is visible the cycle after the request edge.
  - core_in_en and core_key_ready at the same edge: idx is treated as 1. key_round <= rk1; idx <= 2.
  - core_key_ready with idx > 10: ignored; key_round holds.
  - core_out_en: idx <= 1; key_round <= rk0. If core_key_ready is also high at that edge, core_out_en takes priority.
- In IDLE or EXPAND, core_key_ready, core_in_en and core_out_en are ignored; key_round holds.
- S-box: a combinational 256-entry ROM holding the FIPS-197 forward S-box. Exactly one instance.
- No other outputs; no error signalling.

Test Plan:
- FIPS-197 key, key_in = 0f0e0d0c0b0a09080706050403020100, then key_load:
  - key_valid rises exactly 40 cycles after the load edge.
  - rk1 = fe76abd6f178a6dafa72afd2fd74aad6.
  - rk10 = c5302b4d8ba707f3174a94e37f1d1113.
  - key_round = key_in throughout expansion.
- Serve sequence after the FIPS key: pulse in_en, then 10 key_ready pulses spaced 4 cycles apart.
  - key_round steps rk1..rk10, each change one cycle after its request.
  - An 11th key_ready leaves rk10 held.
  - core_out_en returns key_round to 0f0e...00.
- Simultaneous in_en and key_ready mid-block (idx = 6):
  - key_round = rk1 (fe76abd6...).
  - The next request yields rk2 = feb3306800c59bbef1bd3d640bcf92b6.
- Key 3c4fcf098815f7aba6d2ae2816157e2b loaded at cycle 20 of a FIPS expansion:
  - key_valid stays 0 until 40 cycles after the second load.
  - rk10 = a60c63b6c80c3fe18925eec9a8f914d0.
- key_ready pulses while in EXPAND: key_round unchanged and idx unchanged. The first post-valid request yields rk1.
- kill asserted during READY with idx = 5:
  - Next cycle: key_valid = 0, key_round = 0.
  - A following key_ready is ignored until a new key_load completes its expansion.

Source files
------------

// File: rtl/aes_128_key_expand_4cyc.sv
// AES-128 key expansion with one shared S-box: one SubWord byte per cycle, four cycles per round.
// Round keys are stored and then served to the core one per key_ready request.
module aes_128_key_expand_4cyc #(
    parameter int unsigned NR          = 10,
    parameter int unsigned CYC_PER_RND = 4
) (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_valid,
    input  logic         core_in_en,
    input  logic         core_key_ready,
    input  logic         core_out_en,
    output logic [127:0] key_round
);

    localparam logic [3:0] LastRnd  = 4'(NR);
    localparam logic [1:0] LastByte = 2'(CYC_PER_RND - 1);

    localparam logic [7:0] Sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e       state;
    logic [127:0] rk0;
    logic [127:0] work;
    logic [127:0] rk [1:NR];
    logic [3:0]   rnd;
    logic [3:0]   idx;
    logic [1:0]   bcnt;
    logic [23:0]  sub;

    logic [31:0]  temp;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [31:0]  sub_word;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_rk;
    logic         round_done;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // RotWord of w3 with byte 0 at the LSB.
    assign temp = {work[103:96], work[127:104]};

    always_comb begin
        sbox_in = 8'h00;
        case (bcnt)
            2'd0: sbox_in = temp[7:0];
            2'd1: sbox_in = temp[15:8];
            2'd2: sbox_in = temp[23:16];
            2'd3: sbox_in = temp[31:24];
        endcase
    end

    assign sbox_out = Sbox[sbox_in];

    // The last byte comes straight from the ROM so the round closes on the fourth edge.
    assign sub_word   = {sbox_out, sub} ^ {24'h0, rcon(rnd)};
    assign nw0        = work[31:0] ^ sub_word;
    assign nw1        = work[63:32] ^ nw0;
    assign nw2        = work[95:64] ^ nw1;
    assign nw3        = work[127:96] ^ nw2;
    assign next_rk    = {nw3, nw2, nw1, nw0};
    assign round_done = (state == StExpand) && (bcnt == LastByte);

    always_ff @(posedge clk) begin
        if (kill) begin
            state     <= StIdle;
            key_valid <= 1'b0;
            key_round <= '0;
            idx       <= 4'd1;
            rnd       <= 4'd1;
            bcnt      <= 2'd0;
            sub       <= '0;
        end else if (key_load) begin
            rk0       <= key_in;
            work      <= key_in;
            key_round <= key_in;
            key_valid <= 1'b0;
            rnd       <= 4'd1;
            bcnt      <= 2'd0;
            idx       <= 4'd1;
            state     <= StExpand;
        end else begin
            case (state)
                StExpand: begin
                    bcnt <= bcnt + 2'd1;
                    case (bcnt)
                        2'd0: sub[7:0]   <= sbox_out;
                        2'd1: sub[15:8]  <= sbox_out;
                        2'd2: sub[23:16] <= sbox_out;
                        2'd3: begin
                            work <= next_rk;
                            rnd  <= rnd + 4'd1;
                            if (rnd == LastRnd) begin
                                state     <= StReady;
                                key_valid <= 1'b1;
                            end
                        end
                    endcase
                end
                StReady: begin
                    if (core_out_en) begin
                        idx       <= 4'd1;
                        key_round <= rk0;
                    end else if (core_in_en && core_key_ready) begin
                        idx       <= 4'd2;
                        key_round <= rk[1];
                    end else if (core_in_en) begin
                        idx       <= 4'd1;
                        key_round <= rk0;
                    end else if (core_key_ready && (idx <= LastRnd)) begin
                        idx       <= idx + 4'd1;
                        key_round <= rk[idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key file holds no reset; its contents are only read once key_valid is set.
    always_ff @(posedge clk) begin
        if (!kill && !key_load && round_done) begin
            rk[rnd] <= next_rk;
        end
    end

endmodule

// File: tb/tb_aes_128_key_expand_4cyc.sv
// Randomized bench for aes_128_key_expand_4cyc against a GF(2^8)-derived key schedule model.
module tb_aes_128_key_expand_4cyc;

    logic         clk = 1'b0;
    logic         kill;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_valid;
    logic         core_in_en;
    logic         core_key_ready;
    logic         core_out_en;
    logic [127:0] key_round;

    always #5 clk = ~clk;

    aes_128_key_expand_4cyc dut (
        .clk            (clk),
        .kill           (kill),
        .key_in         (key_in),
        .key_load       (key_load),
        .key_valid      (key_valid),
        .core_in_en     (core_in_en),
        .core_key_ready (core_key_ready),
        .core_out_en    (core_out_en),
        .key_round      (key_round)
    );

    localparam logic [127:0] FipsKey  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FipsRk1  = 128'hfe76abd6f178a6dafa72afd2fd74aad6;
    localparam logic [127:0] FipsRk2  = 128'hfeb3306800c59bbef1bd3d640bcf92b6;
    localparam logic [127:0] FipsRk10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] Key2     = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] Key2Rk10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [0:10];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: inverse in GF(2^8) (a^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] x = 8'h01;
        logic [7:0] s;
        logic [7:0] r;
        for (int i = 0; i < 254; i++) x = gmul(x, a);
        s = x;
        r = x;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [7:0] w [0:43][0:3];
        logic [7:0] t [0:3];
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) w[i][b] = key[32*i + 8*b +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
            if (i % 4 == 0) begin
                for (int b = 0; b < 4; b++) t[b] = sbox_m[w[i-1][(b+1)%4]];
                t[0] = t[0] ^ rc;
                rc = xt(rc);
            end
            for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
        end
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++) exp_rk[r][32*c + 8*b +: 8] = w[4*r + c][b];
    endtask

    task automatic do_load(input logic [127:0] key);
        key_in   = key;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("load_key_round", key_round, key);
        check("load_valid", {127'b0, key_valid}, 128'd0);
    endtask

    task automatic wait_expand(input logic [127:0] key, input bit poke);
        for (int c = 1; c <= 40; c++) begin
            core_key_ready = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            core_key_ready = 1'b0;
            check("expand_valid", {127'b0, key_valid}, {127'b0, c == 40});
            check("expand_key_round", key_round, key);
        end
    endtask

    task automatic request(input int i, input int gap);
        core_key_ready = 1'b1;
        tick();
        core_key_ready = 1'b0;
        check("req_key_round", key_round, exp_rk[i]);
        for (int g = 0; g < gap; g++) tick();
        if (gap > 0) check("req_hold", key_round, exp_rk[i]);
    endtask

    task automatic start_block();
        core_in_en = 1'b1;
        tick();
        core_in_en = 1'b0;
        check("in_en_rk0", key_round, exp_rk[0]);
    endtask

    task automatic end_block();
        core_out_en    = 1'b1;
        core_key_ready = 1'b1;
        tick();
        core_out_en    = 1'b0;
        core_key_ready = 1'b0;
        check("out_en_rk0", key_round, exp_rk[0]);
    endtask

    initial begin
        logic [127:0] rkey;
        kill           = 1'b1;
        key_in         = '0;
        key_load       = 1'b0;
        core_in_en     = 1'b0;
        core_key_ready = 1'b0;
        core_out_en    = 1'b0;
        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
        tick();
        tick();
        kill = 1'b0;
        check("reset_valid", {127'b0, key_valid}, 128'd0);
        check("reset_key_round", key_round, 128'd0);
        core_key_ready = 1'b1;
        tick();
        core_key_ready = 1'b0;
        check("idle_ready_ignored", key_round, 128'd0);

        // FIPS-197 key with requests poked during expansion
        model_expand(FipsKey);
        do_load(FipsKey);
        wait_expand(FipsKey, 1'b1);
        request(1, 2);
        check("fips_rk1", key_round, FipsRk1);
        start_block();
        for (int i = 1; i <= 10; i++) request(i, 3);
        check("fips_rk10", key_round, FipsRk10);
        request(10, 1);
        end_block();
        check("fips_out_en", key_round, FipsKey);

        // Simultaneous in_en and key_ready at idx = 6
        start_block();
        for (int i = 1; i <= 5; i++) request(i, 0);
        core_in_en     = 1'b1;
        core_key_ready = 1'b1;
        tick();
        core_in_en     = 1'b0;
        core_key_ready = 1'b0;
        check("inen_ready_rk1", key_round, FipsRk1);
        request(2, 1);
        check("inen_ready_rk2", key_round, FipsRk2);

        // Reload at cycle 20 of an expansion
        do_load(FipsKey);
        for (int c = 1; c < 20; c++) begin
            tick();
            check("reload_valid_low", {127'b0, key_valid}, 128'd0);
        end
        model_expand(Key2);
        do_load(Key2);
        wait_expand(Key2, 1'b0);
        start_block();
        for (int i = 1; i <= 10; i++) request(i, 1);
        check("key2_rk10", key_round, Key2Rk10);

        // kill while serving with idx = 5
        start_block();
        for (int i = 1; i <= 4; i++) request(i, 0);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_valid", {127'b0, key_valid}, 128'd0);
        check("kill_key_round", key_round, 128'd0);
        core_key_ready = 1'b1;
        tick();
        core_key_ready = 1'b0;
        check("kill_ready_ignored", key_round, 128'd0);
        do_load(Key2);
        wait_expand(Key2, 1'b1);
        request(1, 0);

        // Random keys with random request spacing
        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            do_load(rkey);
            wait_expand(rkey, 1'b1);
            start_block();
            for (int i = 1; i <= 10; i++) request(i, int'($urandom_range(0, 4)));
            request(10, int'($urandom_range(0, 2)));
            end_block();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
